// File: rtl/cycle_controller_if.sv
// Sequencer bus: control inputs from decode/datapath, phase and status outputs.
// master drives the request side, slave is the controller.
`ifndef CYCLE_SIZE
`define CYCLE_SIZE 3
`endif
`ifndef CYCLE_EXEC
`define CYCLE_EXEC 2
`endif

interface cycle_controller_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                     run;
  logic                     step;
  logic                     is_halt;
  logic                     is_multi;
  logic                     is_wait;
  logic                     multi_done;
  logic                     in_valid;
  logic [`CYCLE_SIZE-1:0]   cycle;
  logic                     multi_start;
  logic                     in_ack;
  logic                     halted;
  logic                     timeout_err;
  logic [COUNT_WIDTH-1:0]   instr_count;

  modport master (
    output run, step, is_halt, is_multi,
    output is_wait, multi_done, in_valid,
    input  cycle, multi_start, in_ack,
    input  halted, timeout_err, instr_count
  );

  modport slave (
    input  run, step, is_halt, is_multi,
    input  is_wait, multi_done, in_valid,
    output cycle, multi_start, in_ack,
    output halted, timeout_err, instr_count
  );
endinterface

// File: rtl/cycle_controller.sv
// Instruction-cycle sequencer: FETCH/DECODE/EXEC phases with
// multi-cycle and external-input stalls, run/step/halt control.
module cycle_controller #(
  parameter int MULTI_MAX   = 15,
  parameter int COUNT_WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  cycle_controller_if.slave  bus
);

  localparam int CW = $clog2(MULTI_MAX + 1);

  typedef enum logic [2:0] {
    S_PAUSE,
    S_FETCH,
    S_DECODE,
    S_STALL_M,
    S_STALL_W,
    S_EXEC,
    S_HALT
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   terr_q, terr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_PAUSE;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    terr_d          = terr_q;
    count_d         = count_q;
    bus.multi_start = 1'b0;
    bus.in_ack      = 1'b0;
    unique case (state_q)
      S_PAUSE: begin
        if (bus.run || bus.step)
          state_d = S_FETCH;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        cnt_d = '0;
        if (bus.is_halt) begin
          state_d = S_HALT;
        end else if (bus.is_multi) begin
          state_d         = S_STALL_M;
          bus.multi_start = 1'b1;
        end else if (bus.is_wait) begin
          state_d = S_STALL_W;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_STALL_M: begin
        // done in the final allowed stall cycle still completes
        if (bus.multi_done) begin
          state_d = S_EXEC;
        end else if (cnt_q == CW'(MULTI_MAX - 1)) begin
          state_d = S_HALT;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STALL_W: begin
        bus.in_ack = bus.in_valid;
        if (bus.in_valid)
          state_d = S_EXEC;
      end
      S_EXEC: begin
        count_d = count_q + 1'b1;
        state_d = bus.run ? S_FETCH : S_PAUSE;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_PAUSE;
    endcase
  end

  always_comb begin
    bus.cycle = '0;
    unique case (state_q)
      S_FETCH:  bus.cycle = 3'b001;
      S_DECODE: bus.cycle = 3'b010;
      S_EXEC:   bus.cycle = 3'b100;
      default:  bus.cycle = 3'b000;
    endcase
  end

  assign bus.halted      = (state_q == S_HALT);
  assign bus.timeout_err = terr_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_cycle_controller.sv
// Scoreboard bench for cycle_controller: per-cycle expected phase and
// status vectors queued by stimulus, popped and compared by a monitor.
`timescale 1ns/1ps
module tb_cycle_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cycle_controller_if #(.COUNT_WIDTH(4)) bus();

  cycle_controller #(
    .MULTI_MAX(15),
    .COUNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic [2:0] cyc;
    logic       ms;
    logic       ack;
    logic       halted;
    logic       te;
    logic [3:0] cnt;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_a, mon_e;
  int         checks = 0;
  int         errors = 0;
  logic       mon_en = 1'b0;
  logic [3:0] exp_cnt = 4'd0;
  logic       exp_halt = 1'b0;
  logic       exp_te = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_a = {bus.cycle, bus.multi_start, bus.in_ack,
               bus.halted, bus.timeout_err, bus.instr_count};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty t=%0t: output seen, no expected entry", $time);
      end else begin
        mon_e = q.pop_front();
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL sb_cycle t=%0t got cyc=%b ms=%b ack=%b h=%b te=%b cnt=%0d expected cyc=%b ms=%b ack=%b h=%b te=%b cnt=%0d",
                   $time, mon_a.cyc, mon_a.ms, mon_a.ack, mon_a.halted,
                   mon_a.te, mon_a.cnt, mon_e.cyc, mon_e.ms, mon_e.ack,
                   mon_e.halted, mon_e.te, mon_e.cnt);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // queue the expected outputs for the current cycle, then advance
  task automatic cyc(input logic [2:0] c, input logic ms, input logic ack);
    q.push_back({c, ms, ack, exp_halt, exp_te, exp_cnt});
    @(posedge clk);
    #1;
    if (c == 3'b100) exp_cnt = exp_cnt + 4'd1;
  endtask

  task automatic do_reset(input string tag);
    mon_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk({tag, "_cycle"}, 8'(bus.cycle), 8'd0);
    chk({tag, "_ack"}, 8'(bus.in_ack), 8'd0);
    chk({tag, "_ms"}, 8'(bus.multi_start), 8'd0);
    chk({tag, "_cnt"}, 8'(bus.instr_count), 8'd0);
    chk({tag, "_halted"}, 8'(bus.halted), 8'd0);
    chk({tag, "_terr"}, 8'(bus.timeout_err), 8'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    exp_cnt  = 4'd0;
    exp_halt = 1'b0;
    exp_te   = 1'b0;
    mon_en   = 1'b1;
  endtask

  initial begin
    reset          = 1'b1;
    bus.run        = 1'b0;
    bus.step       = 1'b0;
    bus.is_halt    = 1'b0;
    bus.is_multi   = 1'b0;
    bus.is_wait    = 1'b0;
    bus.multi_done = 1'b0;
    bus.in_valid   = 1'b0;
    #2;
    chk("rst_cycle", 8'(bus.cycle), 8'd0);
    chk("rst_cnt", 8'(bus.instr_count), 8'd0);
    chk("rst_halted", 8'(bus.halted), 8'd0);
    chk("rst_terr", 8'(bus.timeout_err), 8'd0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // free run, three plain instructions
    bus.run = 1'b1;
    cyc(3'b000, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(3'b001, 0, 0);
      cyc(3'b010, 0, 0);
      if (i == 2) bus.run = 1'b0;
      cyc(3'b100, 0, 0);
    end
    cyc(3'b000, 0, 0);
    chk("run_cnt3", 8'(bus.instr_count), 8'd3);

    // multi-cycle op, done in 4th stall cycle
    bus.run = 1'b1;
    cyc(3'b000, 0, 0);
    bus.run = 1'b0;
    cyc(3'b001, 0, 0);
    bus.is_multi = 1'b1;
    cyc(3'b010, 1, 0);
    bus.is_multi = 1'b0;
    repeat (3) cyc(3'b000, 0, 0);
    bus.multi_done = 1'b1;
    cyc(3'b000, 0, 0);
    bus.multi_done = 1'b0;
    cyc(3'b100, 0, 0);
    cyc(3'b000, 0, 0);

    // wait op, in_valid asserted during DECODE is ignored
    bus.run = 1'b1;
    cyc(3'b000, 0, 0);
    bus.run = 1'b0;
    cyc(3'b001, 0, 0);
    bus.is_wait  = 1'b1;
    bus.in_valid = 1'b1;
    cyc(3'b010, 0, 0);
    bus.is_wait  = 1'b0;
    bus.in_valid = 1'b0;
    repeat (10) cyc(3'b000, 0, 0);
    bus.in_valid = 1'b1;
    cyc(3'b000, 0, 1);
    bus.in_valid = 1'b0;
    cyc(3'b100, 0, 0);
    cyc(3'b000, 0, 0);

    // single step
    bus.step = 1'b1;
    cyc(3'b000, 0, 0);
    bus.step = 1'b0;
    cyc(3'b001, 0, 0);
    cyc(3'b010, 0, 0);
    cyc(3'b100, 0, 0);
    cyc(3'b000, 0, 0);
    cyc(3'b000, 0, 0);
    chk("step_cnt6", 8'(bus.instr_count), 8'd6);

    // async reset mid STALL_W with in_valid high
    bus.run = 1'b1;
    cyc(3'b000, 0, 0);
    bus.run = 1'b0;
    cyc(3'b001, 0, 0);
    bus.is_wait = 1'b1;
    cyc(3'b010, 0, 0);
    bus.is_wait = 1'b0;
    cyc(3'b000, 0, 0);
    cyc(3'b000, 0, 0);
    mon_en = 1'b0;
    bus.in_valid = 1'b1;
    #1;
    chk("w_ack_comb", 8'(bus.in_ack), 8'd1);
    do_reset("rstw");
    bus.in_valid = 1'b0;

    // 16 instructions: counter 15 -> 0 wrap
    bus.run = 1'b1;
    cyc(3'b000, 0, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(3'b001, 0, 0);
      cyc(3'b010, 0, 0);
      if (i == 15) bus.run = 1'b0;
      cyc(3'b100, 0, 0);
    end
    cyc(3'b000, 0, 0);
    chk("wrap_cnt0", 8'(bus.instr_count), 8'd0);

    // HALT beats is_multi; no EXEC, stays halted
    bus.run = 1'b1;
    cyc(3'b000, 0, 0);
    bus.run = 1'b0;
    cyc(3'b001, 0, 0);
    bus.is_halt  = 1'b1;
    bus.is_multi = 1'b1;
    cyc(3'b010, 0, 0);
    bus.is_halt  = 1'b0;
    bus.is_multi = 1'b0;
    exp_halt = 1'b1;
    bus.run  = 1'b1;
    repeat (4) cyc(3'b000, 0, 0);
    bus.run = 1'b0;
    do_reset("rsth");

    // done in the 15th (last) stall cycle still completes
    bus.run = 1'b1;
    cyc(3'b000, 0, 0);
    bus.run = 1'b0;
    cyc(3'b001, 0, 0);
    bus.is_multi = 1'b1;
    cyc(3'b010, 1, 0);
    bus.is_multi = 1'b0;
    repeat (14) cyc(3'b000, 0, 0);
    bus.multi_done = 1'b1;
    cyc(3'b000, 0, 0);
    bus.multi_done = 1'b0;
    cyc(3'b100, 0, 0);
    cyc(3'b000, 0, 0);

    // timeout: no done within 15 stall cycles
    bus.run = 1'b1;
    cyc(3'b000, 0, 0);
    bus.run = 1'b0;
    cyc(3'b001, 0, 0);
    bus.is_multi = 1'b1;
    cyc(3'b010, 1, 0);
    bus.is_multi = 1'b0;
    repeat (15) cyc(3'b000, 0, 0);
    exp_halt = 1'b1;
    exp_te   = 1'b1;
    bus.multi_done = 1'b1;
    bus.run        = 1'b1;
    repeat (3) cyc(3'b000, 0, 0);
    bus.multi_done = 1'b0;
    bus.run        = 1'b0;
    chk("to_cnt1", 8'(bus.instr_count), 8'd1);
    do_reset("rstt");

    mon_en = 1'b0;
    chk("sb_drain", 8'(q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
